// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared opcode constants, FSM state encoding and jump decode for the hazard controller.
package hazard_ctrl_defs;

  localparam logic [6:0] JAL_OP  = 7'b1101111;
  localparam logic [6:0] JALR_OP = 7'b1100111;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    JUMP_BUB  = 2'd1,
    LOAD_HOLD = 2'd2
  } hz_state_e;

  function automatic logic is_jump(input logic valid, input logic [6:0] opcode);
    return valid & ((opcode == JAL_OP) | (opcode == JALR_OP));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: hold at the ceiling instead of wrapping
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage hazard sequencer: turns jumps, taken branches, load-use and memory wait
// into stall/flush/redirect controls, and counts injected bubble cycles.
module pipeline_hazard_controller
  import hazard_ctrl_defs::*;
#(
  parameter int JUMP_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode_d,
  input  logic             valid_d,
  input  logic             branch_taken_e,
  input  logic             load_use_d,
  input  logic             mem_wait,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             redirect,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [1:0] JCNT_INIT = 2'(JUMP_BUBBLES - 1);
  localparam bit         MULTI_BUB = (JUMP_BUBBLES > 1);

  hz_state_e  state_q, state_d;
  logic [1:0] jcnt_q, jcnt_d;
  logic       jump_s;

  assign jump_s = is_jump(valid_d, opcode_d);

  // priority decode of controls and next state; earlier rules shadow later ones
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    redirect = 1'b0;
    state_d  = state_q;
    jcnt_d   = jcnt_q;
    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
    end else if (branch_taken_e) begin
      flush_d  = 1'b1;
      flush_e  = 1'b1;
      redirect = 1'b1;
      state_d  = RUN;
      jcnt_d   = 2'd0;
    end else if (state_q == JUMP_BUB) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
      jcnt_d  = jcnt_q - 2'd1;
      state_d = (jcnt_q == 2'd1) ? RUN : JUMP_BUB;
    end else if (jump_s && ((state_q == RUN) || (state_q == LOAD_HOLD))) begin
      redirect = 1'b1;
      flush_d  = 1'b1;
      if (MULTI_BUB) begin
        state_d = JUMP_BUB;
        jcnt_d  = JCNT_INIT;
      end else begin
        state_d = RUN;
      end
    end else if (load_use_d && (state_q == RUN)) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      state_d = LOAD_HOLD;
    end else begin
      // LOAD_HOLD drops back here, masking a repeated load-use for one cycle
      state_d = RUN;
    end
  end

  // FSM state and jump bubble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      jcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      jcnt_q  <= jcnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_d | flush_e),
    .count (bubble_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: four controller instances (JUMP_BUBBLES 1/2/3, and a 2-bit counter) on shared inputs.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode_d;
  logic       valid_d, branch_taken_e, load_use_d, mem_wait;

  logic [3:0]  sf, sd, se, fd, fe, rd;
  logic [15:0] bc1, bc2, bc3;
  logic [1:0]  bcc;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ADD  = 7'b0110011;

  // order: stall_f stall_d stall_e flush_d flush_e redirect
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_JUMP = 6'b000101;
  localparam logic [5:0] O_BUB  = 6'b100100;
  localparam logic [5:0] O_BR   = 6'b000111;
  localparam logic [5:0] O_LU   = 6'b110010;
  localparam logic [5:0] O_MW   = 6'b111000;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.JUMP_BUBBLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .opcode_d(opcode_d), .valid_d(valid_d),
    .branch_taken_e(branch_taken_e), .load_use_d(load_use_d), .mem_wait(mem_wait),
    .stall_f(sf[0]), .stall_d(sd[0]), .stall_e(se[0]), .flush_d(fd[0]), .flush_e(fe[0]),
    .redirect(rd[0]), .bubble_count(bc1));
  pipeline_hazard_controller #(.JUMP_BUBBLES(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .opcode_d(opcode_d), .valid_d(valid_d),
    .branch_taken_e(branch_taken_e), .load_use_d(load_use_d), .mem_wait(mem_wait),
    .stall_f(sf[1]), .stall_d(sd[1]), .stall_e(se[1]), .flush_d(fd[1]), .flush_e(fe[1]),
    .redirect(rd[1]), .bubble_count(bc2));
  pipeline_hazard_controller #(.JUMP_BUBBLES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .opcode_d(opcode_d), .valid_d(valid_d),
    .branch_taken_e(branch_taken_e), .load_use_d(load_use_d), .mem_wait(mem_wait),
    .stall_f(sf[2]), .stall_d(sd[2]), .stall_e(se[2]), .flush_d(fd[2]), .flush_e(fe[2]),
    .redirect(rd[2]), .bubble_count(bc3));
  pipeline_hazard_controller #(.JUMP_BUBBLES(1), .CNT_W(2)) uc (
    .clk(clk), .rst(rst), .opcode_d(opcode_d), .valid_d(valid_d),
    .branch_taken_e(branch_taken_e), .load_use_d(load_use_d), .mem_wait(mem_wait),
    .stall_f(sf[3]), .stall_d(sd[3]), .stall_e(se[3]), .flush_d(fd[3]), .flush_e(fe[3]),
    .redirect(rd[3]), .bubble_count(bcc));

  function automatic logic [5:0] outs(input int k);
    return {sf[k], sd[k], se[k], fd[k], fe[k], rd[k]};
  endfunction

  // inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later
  task automatic drive(input logic v, input logic [6:0] op, input logic br,
                       input logic lu, input logic mw);
    valid_d = v; opcode_d = op; branch_taken_e = br; load_use_d = lu; mem_wait = mw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (outs(k) !== O_IDLE) begin
        errors++; $display("FAIL reset_outs inst%0d got %b want %b", k, outs(k), O_IDLE);
      end
    end
    checks++;
    if ({bc1, bc2, bc3, bcc} !== 50'd0) begin
      errors++; $display("FAIL reset_count got %h %h %h %h want 0", bc1, bc2, bc3, bcc);
    end
  endtask

  task automatic test_jal_single();
    do_reset();
    drive(1'b1, OP_JAL, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs(0) !== O_JUMP) begin errors++; $display("FAIL jal1_c0 got %b want %b", outs(0), O_JUMP); end
    tick();
    drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs(0) !== O_IDLE) begin errors++; $display("FAIL jal1_c1 got %b want %b", outs(0), O_IDLE); end
    checks++;
    if (bc1 !== 16'd1) begin errors++; $display("FAIL jal1_count got %0d want 1", bc1); end
    // a non-jump opcode with valid_d must not redirect
    drive(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs(0) !== O_IDLE) begin errors++; $display("FAIL nonjump got %b want %b", outs(0), O_IDLE); end
  endtask

  task automatic test_jalr_three();
    do_reset();
    drive(1'b1, OP_JALR, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs(2) !== O_JUMP) begin errors++; $display("FAIL jalr3_c0 got %b want %b", outs(2), O_JUMP); end
    for (int c = 1; c <= 2; c++) begin
      tick();
      drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs(2) !== O_BUB) begin errors++; $display("FAIL jalr3_c%0d got %b want %b", c, outs(2), O_BUB); end
    end
    tick();
    checks++;
    if (outs(2) !== O_IDLE) begin errors++; $display("FAIL jalr3_c3 got %b want %b", outs(2), O_IDLE); end
    checks++;
    if (bc3 !== 16'd3) begin errors++; $display("FAIL jalr3_count got %0d want 3", bc3); end
  endtask

  task automatic test_branch_abort();
    do_reset();
    drive(1'b1, OP_JAL, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, OP_ADD, 1'b1, 1'b0, 1'b0);
    checks++;
    if (outs(2) !== O_BR) begin errors++; $display("FAIL brabort_c1 got %b want %b", outs(2), O_BR); end
    tick();
    drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs(2) !== O_IDLE) begin errors++; $display("FAIL brabort_c2 got %b want %b", outs(2), O_IDLE); end
    checks++;
    if (bc3 !== 16'd2) begin errors++; $display("FAIL brabort_count got %0d want 2", bc3); end
  endtask

  task automatic test_load_use();
    logic [5:0] exp_lu [3];
    exp_lu[0] = O_LU; exp_lu[1] = O_IDLE; exp_lu[2] = O_LU;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, OP_ADD, 1'b0, 1'b1, 1'b0);
      checks++;
      if (outs(0) !== exp_lu[c]) begin
        errors++; $display("FAIL loaduse_c%0d got %b want %b", c, outs(0), exp_lu[c]);
      end
      tick();
    end
    drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bc1 !== 16'd2) begin errors++; $display("FAIL loaduse_count got %0d want 2", bc1); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive(1'b1, OP_JAL, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs(1) !== O_JUMP) begin errors++; $display("FAIL mw_c0 got %b want %b", outs(1), O_JUMP); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
      checks++;
      if (outs(1) !== O_MW) begin errors++; $display("FAIL mw_c%0d got %b want %b", c, outs(1), O_MW); end
    end
    tick();
    drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs(1) !== O_BUB) begin errors++; $display("FAIL mw_c5 got %b want %b", outs(1), O_BUB); end
    tick();
    checks++;
    if (outs(1) !== O_IDLE) begin errors++; $display("FAIL mw_c6 got %b want %b", outs(1), O_IDLE); end
    checks++;
    if (bc2 !== 16'd2) begin errors++; $display("FAIL mw_count got %0d want 2", bc2); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b0, OP_ADD, 1'b0, 1'b1, 1'b0);
    tick();
    // a jump during the load-hold cycle still redirects
    drive(1'b1, OP_JAL, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outs(0) !== O_JUMP) begin errors++; $display("FAIL b2b_jump got %b want %b", outs(0), O_JUMP); end
    tick();
    drive(1'b0, OP_ADD, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outs(0) !== O_LU) begin errors++; $display("FAIL b2b_lu got %b want %b", outs(0), O_LU); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_c;
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      drive(1'b0, OP_ADD, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
      exp_c = (c > 3) ? 2'd3 : 2'(c);
      checks++;
      if (bcc !== exp_c) begin errors++; $display("FAIL sat_c%0d got %0d want %0d", c, bcc, exp_c); end
    end
    checks++;
    if (bc1 !== 16'd5) begin errors++; $display("FAIL sat_wide got %0d want 5", bc1); end
    drive(1'b1, OP_JAL, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs(2) !== O_IDLE) begin errors++; $display("FAIL rst_midseq got %b want %b", outs(2), O_IDLE); end
    checks++;
    if ({bcc, bc3} !== 18'd0) begin errors++; $display("FAIL rst_count got %0d %0d want 0", bcc, bc3); end
  endtask

  initial begin
    rst = 1'b1;
    valid_d = 1'b0; opcode_d = OP_ADD; branch_taken_e = 1'b0; load_use_d = 1'b0; mem_wait = 1'b0;
    tick();
    test_reset();
    test_jal_single();
    test_jalr_three();
    test_branch_abort();
    test_load_use();
    test_mem_wait();
    test_back_to_back();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Decode-stage pipeline sequencer for the RISC-V core. It combines jump detection (JAL/JALR in decode), taken branches resolved in execute, load-use hazards and data-memory wait. From these it drives the per-stage stall and flush controls and the PC redirect select. A small FSM handles multi-bubble jump injection and load-use stall de-duplication. A saturating counter records injected bubbles for performance debug.

## Interface
- JUMP_BUBBLES, 1, total bubbles inserted after a decode-stage jump; legal 1..3
- CNT_W, 16, width of bubble_count
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode_d  in  7  opcode of the instruction in decode
- valid_d  in  1  decode holds a valid instruction
- branch_taken_e  in  1  branch in execute resolved taken
- load_use_d  in  1  load-use hazard detected against decode
- mem_wait  in  1  data memory not ready; whole pipe must freeze
- stall_f  out  1  hold PC and IF/ID
- stall_d  out  1  hold ID/EX source operands / decode
- stall_e  out  1  hold EX/MEM
- flush_d  out  1  IF/ID loads NOP
- flush_e  out  1  ID/EX loads NOP
- redirect  out  1  PC mux selects jump/branch target
- bubble_count  out  CNT_W  saturating count of bubble-cycles

## Operation
- States: RUN, JUMP_BUB, LOAD_HOLD. Reset state is RUN. jcnt is a 2-bit counter, reset 0.
- jump_d = valid_d & (opcode_d == JAL or JALR).
- Outputs are combinational from the current state and inputs. Evaluate in priority order; the first match wins and all unlisted outputs are 0.
- 1. mem_wait=1 (any state):
  - stall_f=stall_d=stall_e=1.
  - State and jcnt hold.
  - Nothing else is evaluated.
- 2. branch_taken_e=1 (any state):
  - flush_d=flush_e=redirect=1.
  - Next state RUN, jcnt←0.
  - A pending jump or load-use is discarded because it is younger.
- 3. State JUMP_BUB:
  - stall_f=1, flush_d=1.
  - jcnt←jcnt-1. Next state is RUN when jcnt==1, otherwise JUMP_BUB.
- 4. jump_d=1 (RUN or LOAD_HOLD):
  - redirect=1, flush_d=1.
  - If JUMP_BUBBLES>1: next state JUMP_BUB, jcnt←JUMP_BUBBLES-1. Otherwise stay in RUN.
- 5. load_use_d=1 in RUN:
  - stall_f=stall_d=1, flush_e=1.
  - Next state LOAD_HOLD.
- 6. Default: next state RUN. This includes load_use_d=1 while in LOAD_HOLD, which is masked for exactly one cycle.
- bubble_count:
  - Increments by 1 on every edge where (flush_d | flush_e)=1 and rst=0.
  - Saturates at 2^CNT_W-1 and never wraps.
- Reset mid-sequence (JUMP_BUB or LOAD_HOLD) aborts the sequence. The next cycle starts in RUN with bubble_count=0.

## Timing
- Outputs while rst=1 are undefined-free: the state is forced only at the edge, but all outputs follow the rules above from the RUN state. From the first cycle after reset, all outputs are 0 unless inputs dictate otherwise, and bubble_count=0.
- Zero-cycle latency from any input to stall/flush/redirect; these are combinational within the cycle.
- State, jcnt and bubble_count have 1-cycle latency (registered).
- Jump total bubble cycles = JUMP_BUBBLES, excluding any mem_wait freeze cycles inserted between them.
- A load-use stall lasts exactly 1 cycle. Back-to-back load_use_d produces one stall, then one free cycle.
- mem_wait asserted for N cycles extends any sequence by exactly N cycles. No bubble is counted during freeze.

## Structure
- Shared package/include hazard_ctrl_defs:
  - opcode constants JAL_OP=7'b1101111, JALR_OP=7'b1100111
  - state encodings RUN=2'd0, JUMP_BUB=2'd1, LOAD_HOLD=2'd2
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated for bubble_count.
- FSM, jcnt and the output decode live in the top module.

## Test plan
- Reset, then valid_d=1 with opcode 1101111 (JUMP_BUBBLES=1) -> redirect=1 and flush_d=1 in the same cycle; state stays RUN; bubble_count=1 the next cycle.
- JUMP_BUBBLES=3, JALR (1100111) in decode -> cycle 0: redirect+flush_d. Cycles 1–2: stall_f+flush_d, redirect=0. Cycle 3: all 0. bubble_count=3.
- JUMP_BUBBLES=3, JAL, then branch_taken_e=1 in cycle 1 -> cycle 1 shows flush_d=flush_e=redirect=1; cycle 2 is RUN with all 0; bubble_count=2.
- load_use_d held at 1 for 3 cycles -> stall_f/stall_d/flush_e=1 in cycles 0 and 2 only; cycle 1 is all 0.
- JUMP_BUBBLES=2, JAL, then mem_wait=1 for cycles 1–4 -> cycles 1–4 show stall_f/d/e=1 and flush_d=0; cycle 5 shows stall_f+flush_d; bubble_count=2.
- CNT_W=2, sustained branch_taken_e for 5 cycles -> bubble_count reaches 3 and holds; rst=1 for one cycle -> bubble_count=0 and state RUN.
